tim6_cnt_core: RTL

Counting engine of basic timer TIM6; consumes the control bits and buffered PSC/ARR produced by the TIM6 register block and generates the update event back to it. Holds the prescaler counter, the 16-bit main counter, and the active (shadow) PSC/ARR copies. Drives the update-event pulse, the UIF-set request, and the OPM CEN-clear request. Also accepts software writes of CNT.

---
 rtl/tim6_cnt_core_if.sv | 49 ++++
 rtl/tim6_cnt_core.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tim6_cnt_core_if.sv
// Bundle of control, buffered-register and status signals exchanged between
// the TIM6 register block (master) and the counting engine (slave).
//
// All strobes on this bundle (i_ug, i_cnt_wr, o_uev, o_set_uif, o_cen_clr)
// are single-cycle pulses qualified only by being high on a clk edge; there
// is no valid/ready back-pressure, so each pulse is consumed on the edge it
// is seen and never needs to be held.
interface tim6_cnt_core_if #(
   parameter int CNT_W = 16
);
   // Control bits from CR1/EGR
   logic             i_tick;
   logic             i_cen;
   logic             i_udis;
   logic             i_urs;
   logic             i_opm;
   logic             i_arpe;
   logic             i_ug;
   // Buffered (preload) register values
   logic [CNT_W-1:0] i_bpsc;
   logic [CNT_W-1:0] i_barr;
   // Software CNT write
   logic             i_cnt_wr;
   logic [CNT_W-1:0] i_cnt_wdata;
   // Counter status and event requests back to the register block
   logic [CNT_W-1:0] o_cnt;
   logic             o_uev;
   logic             o_set_uif;
   logic             o_cen_clr;
   logic [CNT_W-1:0] o_psc_act;
   logic [CNT_W-1:0] o_arr_act;
   // Observability of internal state
   logic [CNT_W-1:0] o_dbg_psc_cnt;
   logic             o_dbg_opm_halted;

   modport master (
      output i_tick, i_cen, i_udis, i_urs, i_opm, i_arpe, i_ug,
      output i_bpsc, i_barr, i_cnt_wr, i_cnt_wdata,
      input  o_cnt, o_uev, o_set_uif, o_cen_clr, o_psc_act, o_arr_act,
      input  o_dbg_psc_cnt, o_dbg_opm_halted
   );

   modport slave (
      input  i_tick, i_cen, i_udis, i_urs, i_opm, i_arpe, i_ug,
      input  i_bpsc, i_barr, i_cnt_wr, i_cnt_wdata,
      output o_cnt, o_uev, o_set_uif, o_cen_clr, o_psc_act, o_arr_act,
      output o_dbg_psc_cnt, o_dbg_opm_halted
   );
endinterface

// File: rtl/tim6_cnt_core.sv
// TIM6 counting engine: prescaler counter, 16-bit up-counter with
// auto-reload, active (shadow) PSC/ARR copies, update-event generation and
// one-pulse-mode halt. Update-event side effects (shadow loads) happen on the
// causing edge; the event/flag pulses are registered and appear one cycle
// later.
module tim6_cnt_core #(
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   tim6_cnt_core_if.slave  bus
);

   // One-pulse-mode halt state: after an OPM overflow the counter parks at 0
   // until CEN is seen low, which re-arms it.
   typedef enum logic {
      ST_ARMED  = 1'b0,
      ST_HALTED = 1'b1
   } opm_state_t;

   opm_state_t       state_q, state_d;

   logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] psc_act_q, psc_act_d;
   logic [CNT_W-1:0] arr_act_q, arr_act_d;
   logic             uev_q, uev_d;
   logic             set_uif_q, set_uif_d;
   logic             cen_clr_q, cen_clr_d;

   // Per-cycle qualifiers
   logic             run;
   logic             cnt_step;
   logic             ovf;
   logic             uev_now;

   // Decode this cycle's counting step, overflow and update event.
   // A software CNT write supersedes the counting step for CNT, so it also
   // suppresses the overflow that step would have produced.
   always_comb begin
      run      = 1'b0;
      cnt_step = 1'b0;
      ovf      = 1'b0;
      uev_now  = 1'b0;

      run      = bus.i_cen & (state_q == ST_ARMED) & bus.i_tick;
      cnt_step = run & (psc_cnt_q == psc_act_q);
      ovf      = cnt_step & ~bus.i_cnt_wr & (arr_act_q != '0) & (cnt_q == arr_act_q);
      uev_now  = ~bus.i_udis & (ovf | bus.i_ug);
   end

   // Prescaler and main counter next values: UG > CNT write > counting.
   always_comb begin
      psc_cnt_d = psc_cnt_q;
      cnt_d     = cnt_q;

      if (bus.i_ug) begin
         psc_cnt_d = '0;
      end else if (run) begin
         psc_cnt_d = (psc_cnt_q == psc_act_q) ? '0 : psc_cnt_q + CNT_W'(1);
      end

      if (bus.i_ug) begin
         cnt_d = '0;
      end else if (bus.i_cnt_wr) begin
         cnt_d = bus.i_cnt_wdata;
      end else if (cnt_step) begin
         // ARR=0 holds the counter; a counter above ARR free-runs to the
         // wrap with no overflow because only equality reloads it.
         if ((arr_act_q == '0) || (cnt_q == arr_act_q)) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Shadow registers: PSC only on an update event; ARR follows the buffer
   // directly when preload is off, otherwise only on an update event.
   always_comb begin
      psc_act_d = psc_act_q;
      arr_act_d = arr_act_q;

      if (uev_now) begin
         psc_act_d = bus.i_bpsc;
      end

      if (!bus.i_arpe || uev_now) begin
         arr_act_d = bus.i_barr;
      end
   end

   // Event pulses, registered so they appear the cycle after the cause.
   // A UG coinciding with a qualifying overflow still sets UIF even with URS.
   always_comb begin
      uev_d     = 1'b0;
      set_uif_d = 1'b0;
      cen_clr_d = 1'b0;

      uev_d     = uev_now;
      set_uif_d = ~bus.i_udis & (ovf | (bus.i_ug & ~bus.i_urs));
      cen_clr_d = ovf & bus.i_opm;
   end

   // OPM halt next state: CEN low re-arms; an OPM overflow halts.
   always_comb begin
      state_d = state_q;

      case (state_q)
         ST_ARMED: begin
            if (ovf && bus.i_opm) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (!bus.i_cen) begin
               state_d = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_ARMED;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_ARMED;
         psc_cnt_q <= '0;
         cnt_q     <= '0;
         psc_act_q <= '0;
         arr_act_q <= '0;
         uev_q     <= 1'b0;
         set_uif_q <= 1'b0;
         cen_clr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         psc_cnt_q <= psc_cnt_d;
         cnt_q     <= cnt_d;
         psc_act_q <= psc_act_d;
         arr_act_q <= arr_act_d;
         uev_q     <= uev_d;
         set_uif_q <= set_uif_d;
         cen_clr_q <= cen_clr_d;
      end
   end

   // Output mapping
   always_comb begin
      bus.o_cnt            = cnt_q;
      bus.o_uev            = uev_q;
      bus.o_set_uif        = set_uif_q;
      bus.o_cen_clr        = cen_clr_q;
      bus.o_psc_act        = psc_act_q;
      bus.o_arr_act        = arr_act_q;
      bus.o_dbg_psc_cnt    = psc_cnt_q;
      bus.o_dbg_opm_halted = (state_q == ST_HALTED);
   end

endmodule
